// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types and helpers for the weighted round-robin lock arbiter
package rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Widest one-hot vector the helpers can build; bounds REQUIRE_NUM.
  localparam int MAX_REQ = 32;

  // Index width for n requesters, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One-hot vector with bit idx set, wide enough for any supported requester count.
  function automatic logic [MAX_REQ-1:0] onehot(input int idx);
    logic [MAX_REQ-1:0] v;
    v = {{(MAX_REQ-1){1'b0}}, 1'b1} << idx;
    return v;
  endfunction

  // (idx + 1) mod n with an explicit compare, so non-power-of-two counts wrap correctly.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wrr_lock_arbiter_rr_pick.sv
// rtl/wrr_lock_arbiter_rr_pick.sv - combinational rotating-priority selector
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [N-1:0]     sel_oh,
  output logic [IDX_W-1:0] sel_idx
);

  localparam logic [2*N-1:0] ONE = (2*N)'(1);

  logic [2*N-1:0] dbl_req;
  logic [2*N-1:0] below_ptr;
  logic [2*N-1:0] masked;
  logic [2*N-1:0] lowest;

  // Mask requests below ptr in the lower copy; the upper copy supplies the wrapped-around
  // candidates, and the lowest surviving bit folded back onto N bits is the winner.
  always_comb begin
    dbl_req   = {req, req};
    below_ptr = (ONE << ptr) - ONE;
    masked    = dbl_req & ~below_ptr;
    lowest    = masked & (~masked + ONE);
    sel_oh    = lowest[N-1:0] | lowest[2*N-1:N];
    found     = |req;
    sel_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_oh[i]) sel_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/wrr_lock_arbiter.sv
// rtl/wrr_lock_arbiter.sv - weighted round-robin arbiter holding the grant until packet end
module wrr_lock_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int REQUIRE_NUM = 4,
  parameter  int WEIGHT_W    = 4,
  localparam int IDX_W       = idx_w(REQUIRE_NUM)
) (
  input  logic                            sys_clk_i,
  input  logic                            rst_n_i,
  input  logic [REQUIRE_NUM-1:0]          request_i,
  input  logic [REQUIRE_NUM-1:0]          last_i,
  input  logic [REQUIRE_NUM*WEIGHT_W-1:0] weight_i,
  input  logic                            ready_i,
  output logic [REQUIRE_NUM-1:0]          grant_o,
  output logic [IDX_W-1:0]                grant_idx_o,
  output logic                            grant_vld_o
);

  arb_state_e           state_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [WEIGHT_W-1:0]  credit_q;
  logic                 in_pkt_q;

  logic                   pick_found;
  logic [REQUIRE_NUM-1:0] pick_oh;
  logic [IDX_W-1:0]       pick_idx;
  logic [IDX_W-1:0]       next_ptr;
  logic [WEIGHT_W-1:0]    pick_weight;
  logic [WEIGHT_W-1:0]    reload_credit;

  logic hold_req;
  logic hold_last;
  logic beat;
  logic last_beat;
  logic release_now;
  logic take;

  rr_pick #(
    .N     (REQUIRE_NUM),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (request_i),
    .ptr     (ptr_q),
    .found   (pick_found),
    .sel_oh  (pick_oh),
    .sel_idx (pick_idx)
  );

  assign next_ptr = IDX_W'(wrap_inc(int'(pick_idx), REQUIRE_NUM));

  // Weight of the candidate winner, with a zero field meaning one packet per turn.
  always_comb begin
    pick_weight = '0;
    for (int k = 0; k < REQUIRE_NUM; k++) begin
      if (pick_idx == IDX_W'(k)) pick_weight = weight_i[k*WEIGHT_W +: WEIGHT_W];
    end
    reload_credit = (pick_weight == '0) ? WEIGHT_W'(1) : pick_weight;
  end

  // Holder-side view: beats, packet ends, and when the turn is over.
  always_comb begin
    hold_req    = request_i[grant_idx_o];
    hold_last   = last_i[grant_idx_o];
    beat        = ready_i & hold_req;
    last_beat   = beat & hold_last;
    release_now = (last_beat && credit_q == WEIGHT_W'(1)) || (!in_pkt_q && !hold_req);
    take        = pick_found && (state_q == IDLE || release_now);
  end

  // Grant FSM: arbitrate when idle or on release, otherwise track packets and credit.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      credit_q    <= '0;
      in_pkt_q    <= 1'b0;
      grant_o     <= '0;
      grant_idx_o <= '0;
      grant_vld_o <= 1'b0;
    end else if (take) begin
      state_q     <= GRANT;
      grant_o     <= pick_oh;
      grant_idx_o <= pick_idx;
      grant_vld_o <= 1'b1;
      ptr_q       <= next_ptr;
      credit_q    <= reload_credit;
      in_pkt_q    <= 1'b0;
    end else if (state_q == GRANT) begin
      if (release_now) begin
        state_q     <= IDLE;
        grant_o     <= '0;
        grant_idx_o <= '0;
        grant_vld_o <= 1'b0;
        in_pkt_q    <= 1'b0;
      end else if (last_beat) begin
        credit_q <= credit_q - WEIGHT_W'(1);
        in_pkt_q <= 1'b0;
      end else if (beat) begin
        in_pkt_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wrr_lock_arbiter.sv
// tb/tb_wrr_lock_arbiter.sv - self-checking bench for wrr_lock_arbiter
module tb_wrr_lock_arbiter;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, last;
  logic        ready;
  logic [15:0] wt;
  logic [3:0]  grant;
  logic [1:0]  gidx;
  logic        gvld;

  logic [2:0]  req3, last3;
  logic [11:0] wt3;
  logic [2:0]  grant3;
  logic [1:0]  gidx3;
  logic        gvld3;

  int errors = 0;
  int checks = 0;

  always #5 sys_clk = ~sys_clk;

  wrr_lock_arbiter #(.REQUIRE_NUM(4), .WEIGHT_W(4)) dut (
    .sys_clk_i   (sys_clk),
    .rst_n_i     (rst_n),
    .request_i   (req),
    .last_i      (last),
    .weight_i    (wt),
    .ready_i     (ready),
    .grant_o     (grant),
    .grant_idx_o (gidx),
    .grant_vld_o (gvld)
  );

  wrr_lock_arbiter #(.REQUIRE_NUM(3), .WEIGHT_W(4)) dut3 (
    .sys_clk_i   (sys_clk),
    .rst_n_i     (rst_n),
    .request_i   (req3),
    .last_i      (last3),
    .weight_i    (wt3),
    .ready_i     (ready),
    .grant_o     (grant3),
    .grant_idx_o (gidx3),
    .grant_vld_o (gvld3)
  );

  typedef struct {
    bit          do_rst;
    logic [3:0]  req;
    logic [3:0]  last;
    bit          ready;
    logic [15:0] wt;
    int          exp_idx;
    bit          exp_vld;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: who holds the grant, rotation pointer, credit, packet flag.
  bit m_vld;
  int m_idx, m_ptr, m_credit;
  bit m_inpkt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req = '0; last = '0; ready = 1'b0; wt = '0;
    req3 = '0; last3 = '0; wt3 = '0;
    #3;
    rst_n = 1'b1;
    m_vld = 0; m_idx = 0; m_ptr = 0; m_credit = 0; m_inpkt = 0;
  endtask

  function automatic int model_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (p + k) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_take(input int w);
    m_vld    = 1;
    m_idx    = w;
    m_ptr    = (w + 1) % 4;
    m_credit = int'((wt >> (4 * w)) & 16'hF);
    if (m_credit == 0) m_credit = 1;
    m_inpkt  = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit rel;
    bit beat;
    int w;
    rel = 1;
    if (m_vld) begin
      rel  = 0;
      beat = ready && req[m_idx];
      if (beat && last[m_idx]) begin
        m_inpkt = 0;
        if (m_credit > 1) m_credit--;
        else rel = 1;
      end else if (beat) begin
        m_inpkt = 1;
      end else if (!m_inpkt && !req[m_idx]) begin
        rel = 1;
      end
    end
    if (rel) begin
      w = model_pick(req, m_ptr);
      if (w >= 0) model_take(w);
      else begin
        m_vld = 0; m_idx = 0; m_inpkt = 0;
      end
    end
  endtask

  initial begin
    logic [3:0] eg;
    int         exp3[4];

    rst_n = 1'b0;
    req = '0; last = '0; ready = 1'b0; wt = '0;
    req3 = '0; last3 = '0; wt3 = '0;
    cyc();
    cyc();
    check("reset_vld", 32'(gvld), 32'd0);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_idx", 32'(gidx), 32'd0);
    check("reset_vld3", 32'(gvld3), 32'd0);

    // Rotation with all requesting, weighted turns with a zero weight, sole requester.
    vecs.push_back('{1'b1, 4'b1111, 4'b1111, 1'b1, 16'h1111, 0, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 16'h1111, 1, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 16'h1111, 2, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 16'h1111, 3, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 16'h1111, 0, 1'b1});
    vecs.push_back('{1'b1, 4'b0011, 4'b1111, 1'b1, 16'h0003, 0, 1'b1});
    vecs.push_back('{1'b0, 4'b0011, 4'b1111, 1'b1, 16'h0003, 0, 1'b1});
    vecs.push_back('{1'b0, 4'b0011, 4'b1111, 1'b1, 16'h0003, 0, 1'b1});
    vecs.push_back('{1'b0, 4'b0011, 4'b1111, 1'b1, 16'h0003, 1, 1'b1});
    vecs.push_back('{1'b0, 4'b0011, 4'b1111, 1'b1, 16'h0003, 0, 1'b1});
    vecs.push_back('{1'b0, 4'b0011, 4'b1111, 1'b1, 16'h0003, 0, 1'b1});
    vecs.push_back('{1'b0, 4'b0011, 4'b1111, 1'b1, 16'h0003, 0, 1'b1});
    vecs.push_back('{1'b0, 4'b0011, 4'b1111, 1'b1, 16'h0003, 1, 1'b1});
    vecs.push_back('{1'b1, 4'b0001, 4'b0001, 1'b1, 16'h1111, 0, 1'b1});
    vecs.push_back('{1'b0, 4'b0001, 4'b0001, 1'b1, 16'h1111, 0, 1'b1});
    vecs.push_back('{1'b0, 4'b0000, 4'b0000, 1'b1, 16'h1111, 0, 1'b0});

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) apply_reset();
      req = vecs[i].req; last = vecs[i].last; ready = vecs[i].ready; wt = vecs[i].wt;
      cyc();
      eg = vecs[i].exp_vld ? (4'b0001 << vecs[i].exp_idx) : 4'b0000;
      check($sformatf("vec%0d_idx", i), 32'(gidx), 32'(vecs[i].exp_idx));
      check($sformatf("vec%0d_vld", i), 32'(gvld), 32'(vecs[i].exp_vld));
      check($sformatf("vec%0d_grant", i), 32'(grant), 32'(eg));
    end

    // Three requesters, 0 and 2 active: pointer must wrap from 2 back to 0.
    apply_reset();
    req3 = 3'b101; last3 = 3'b111; wt3 = 12'h111; ready = 1'b1;
    exp3 = '{0, 2, 0, 2};
    for (int i = 0; i < 4; i++) begin
      cyc();
      check($sformatf("n3_idx%0d", i), 32'(gidx3), 32'(exp3[i]));
      check($sformatf("n3_grant%0d", i), 32'(grant3), 32'(3'b001 << exp3[i]));
    end

    // Locked 4-beat packet from requester 1 with ready and request stalls.
    apply_reset();
    wt = 16'h1111; ready = 1'b1; req = 4'b0110; last = 4'b0000;
    cyc(); check("lock_grant", 32'(grant), 32'b0010);
    cyc(); check("lock_beat1", 32'(grant), 32'b0010);
    ready = 1'b0;
    cyc(); check("lock_notready", 32'(grant), 32'b0010);
    ready = 1'b1;
    cyc(); check("lock_beat2", 32'(grant), 32'b0010);
    req = 4'b0100;
    cyc(); check("lock_reqstall", 32'(grant), 32'b0010);
    req = 4'b0110;
    cyc(); check("lock_beat3", 32'(grant), 32'b0010);
    last = 4'b0010;
    cyc(); check("lock_handoff", 32'(grant), 32'b0100);
    check("lock_handoff_idx", 32'(gidx), 32'd2);

    // Asynchronous reset in the middle of requester 2's packet.
    apply_reset();
    wt = 16'h1111; ready = 1'b1; req = 4'b0100; last = 4'b0000;
    cyc(); check("rst_pre_idx", 32'(gidx), 32'd2);
    cyc();
    rst_n = 1'b0;
    #1;
    check("rst_async_grant", 32'(grant), 32'd0);
    check("rst_async_vld", 32'(gvld), 32'd0);
    check("rst_async_idx", 32'(gidx), 32'd0);
    #2;
    rst_n = 1'b1;
    req = 4'b1111;
    cyc(); check("rst_after_idx", 32'(gidx), 32'd0);
    check("rst_after_vld", 32'(gvld), 32'd1);

    // Random traffic against the reference model.
    apply_reset();
    for (int n = 0; n < 1500; n++) begin
      req   = 4'($urandom);
      ready = ($urandom % 4) != 0;
      for (int b = 0; b < 4; b++) last[b] = ($urandom % 3) == 0;
      for (int b = 0; b < 4; b++) wt[4*b +: 4] = 4'($urandom % 4);
      model_step();
      cyc();
      check("rand_vld", 32'(gvld), 32'(m_vld));
      check("rand_idx", 32'(gidx), 32'(m_idx));
      check("rand_grant", 32'(grant), m_vld ? (32'd1 << m_idx) : 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
